// File: rtl/sha256_pad_if.sv
// sha256_pad_if -- byte-stream input and padded-block output bundle for sha256_pad.
//   in_data/in_valid/in_last/in_empty : byte stream (in_empty+in_last = end marker, no byte)
//   in_ready                          : pad block can accept a transfer
//   blk[0:511]/blk_valid/blk_last     : padded 512-bit block, byte n at bits [8n:8n+7]
//   blk_ready                         : consumer accepts blk
// modport master : message producer / block consumer side
// modport slave  : the padding block
interface sha256_pad_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [0:511] blk;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;

  modport master (
    output in_data, in_valid, in_last, in_empty, blk_ready,
    input  in_ready, blk, blk_valid, blk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_empty, blk_ready,
    output in_ready, blk, blk_valid, blk_last
  );
endinterface

// File: rtl/sha256_pad.sv
// sha256_pad -- SHA-256 message padder. Collects a byte stream into 512-bit
// blocks and appends the 0x80 marker, zero fill and 64-bit big-endian bit
// length, emitting one, two or (via tail blocks) extra blocks per message.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : sha256_pad_if.slave (byte input stream, block output stream)
//   ovf    : (only with SHA256_PAD_OVF_EN) length counter wrapped in this message
// Parameter LEN_W: bit-length counter width; length field is it zero-extended.
// Optional feature macro: SHA256_PAD_OVF_EN.
module sha256_pad #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  sha256_pad_if.slave  bus
`ifdef SHA256_PAD_OVF_EN
  ,
  output logic         ovf
`endif
);

  // EMIT holds blocks carrying message data; TAIL_A/TAIL_B hold the
  // trailing 0x80+length and length-only blocks.
  typedef enum logic [1:0] {FILL, EMIT, TAIL_A, TAIL_B} state_t;
  // What follows acceptance of a non-final EMIT block.
  typedef enum logic [1:0] {T_NONE, T_A, T_B} tail_t;

  state_t           state_q, state_d;
  tail_t            tail_q, tail_d;
  logic [5:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [0:511]     blk_q, blk_d;
  logic             blk_valid_q, blk_valid_d;
  logic             blk_last_q, blk_last_d;

  logic             in_acc, blk_acc, wr;
  logic [6:0]       p;
  logic [63:0]      len64;
  logic [LEN_W-1:0] len_inc;

`ifdef SHA256_PAD_OVF_EN
  logic             ovf_q, ovf_d;
  logic [LEN_W:0]   len_sum;
  assign len_sum = {1'b0, len_q} + (LEN_W+1)'(8);
  assign len_inc = len_sum[LEN_W-1:0];
  assign ovf     = ovf_q;
`else
  assign len_inc = len_q + LEN_W'(8);
`endif

  assign in_acc  = bus.in_valid && (state_q == FILL);
  assign blk_acc = blk_valid_q && bus.blk_ready;
  // An end marker (in_last+in_empty) carries no byte; in_empty alone is ignored.
  assign wr      = in_acc && !(bus.in_last && bus.in_empty);
  // Final byte count of the buffer after this transfer (0..64).
  assign p       = {1'b0, ptr_q} + {6'd0, wr};

  always_comb begin
    state_d     = state_q;
    tail_d      = tail_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    blk_d       = blk_q;
    blk_valid_d = blk_valid_q;
    blk_last_d  = blk_last_q;
    len64       = '0;
`ifdef SHA256_PAD_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      FILL: begin
        if (in_acc) begin
          if (wr) begin
            blk_d[{ptr_q, 3'b000} +: 8] = bus.in_data;
            len_d = len_inc;
`ifdef SHA256_PAD_OVF_EN
            if (len_sum[LEN_W]) ovf_d = 1'b1;
`endif
          end
          ptr_d = p[5:0];
          len64 = 64'(len_d);
          if (bus.in_last) begin
            ptr_d = '0;
            if (p == 7'd0) begin
              // Nothing buffered: the whole pad is a single 0x80+length block.
              state_d        = TAIL_A;
              blk_d          = '0;
              blk_d[0 +: 8]  = 8'h80;
              blk_d[448+:64] = len64;
              blk_valid_d    = 1'b1;
              blk_last_d     = 1'b1;
            end else if (p <= 7'd55) begin
              state_d        = EMIT;
              blk_d[{p[5:0], 3'b000} +: 8] = 8'h80;
              blk_d[448+:64] = len64;
              blk_valid_d    = 1'b1;
              blk_last_d     = 1'b1;
              tail_d         = T_NONE;
            end else if (p <= 7'd63) begin
              // No room for the length: marker here, length in a second block.
              state_d        = EMIT;
              blk_d[{p[5:0], 3'b000} +: 8] = 8'h80;
              blk_valid_d    = 1'b1;
              blk_last_d     = 1'b0;
              tail_d         = T_B;
            end else begin
              state_d        = EMIT;
              blk_valid_d    = 1'b1;
              blk_last_d     = 1'b0;
              tail_d         = T_A;
            end
          end else if (p == 7'd64) begin
            state_d     = EMIT;
            blk_valid_d = 1'b1;
            blk_last_d  = 1'b0;
            tail_d      = T_NONE;
          end
        end
      end

      default: begin
        // EMIT, TAIL_A, TAIL_B: hold the block until the consumer takes it.
        if (blk_acc) begin
          blk_valid_d = 1'b0;
          blk_last_d  = 1'b0;
          tail_d      = T_NONE;
          blk_d       = '0;
          len64       = 64'(len_q);
          if (blk_last_q) begin
            state_d = FILL;
            ptr_d   = '0;
            len_d   = '0;
`ifdef SHA256_PAD_OVF_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            case (tail_q)
              T_A: begin
                state_d        = TAIL_A;
                blk_d[0 +: 8]  = 8'h80;
                blk_d[448+:64] = len64;
                blk_valid_d    = 1'b1;
                blk_last_d     = 1'b1;
              end
              T_B: begin
                state_d        = TAIL_B;
                blk_d[448+:64] = len64;
                blk_valid_d    = 1'b1;
                blk_last_d     = 1'b1;
              end
              default: begin
                // Mid-message full block taken: keep collecting.
                state_d = FILL;
                ptr_d   = '0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      tail_q      <= T_NONE;
      ptr_q       <= '0;
      len_q       <= '0;
      blk_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
`ifdef SHA256_PAD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tail_q      <= tail_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      blk_q       <= blk_d;
      blk_valid_q <= blk_valid_d;
      blk_last_q  <= blk_last_d;
`ifdef SHA256_PAD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.blk       = blk_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_pad.sv
// tb_sha256_pad -- self-checking bench for sha256_pad: table of messages
// checked against a reference padding model through a block scoreboard,
// plus hand sequences for latency, back-pressure and mid-message reset.
module tb_sha256_pad;
  logic clk = 1'b0;
  logic reset;
  sha256_pad_if bus ();
`ifdef SHA256_PAD_OVF_EN
  logic ovf;
`endif

  sha256_pad dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SHA256_PAD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:511] b;
    logic         last;
  } exp_t;

  typedef struct {
    int         n;          // message length in bytes
    int         mode;       // 0: constant val, 1: val+i
    logic [7:0] val;
    bit         emk;        // terminate with an empty end-marker
    int         exp_blocks; // blocks the padded message must occupy
  } vec_t;

  exp_t       sb[$];
  logic [7:0] msg_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         nblk = 0;

  task automatic chk(input bit ok, input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic push_expected();
    logic [7:0]  pad[$];
    logic [63:0] lenbits;
    exp_t        e;
    int          nb;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    lenbits = 64'(msg_q.size()) * 64'd8;
    for (int i = 0; i < 8; i++) pad.push_back(lenbits[63-8*i -: 8]);
    nb = pad.size() / 64;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) e.b[8*j +: 8] = pad[64*k+j];
      e.last = (k == nb - 1);
      sb.push_back(e);
    end
  endtask

  // Scoreboard: a block is taken on the edge following a negedge with valid&&ready.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.blk_valid && bus.blk_ready) begin
      nblk++;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_block", 512'(bus.blk), '0);
      end else begin
        e = sb.pop_front();
        chk(bus.blk === e.b, "blk_data", 512'(bus.blk), 512'(e.b));
        chk(bus.blk_last === e.last, "blk_last", 512'(bus.blk_last), 512'(e.last));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic xfer(input logic [7:0] d, input logic last, input logic empty);
    bit rdy;
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    do begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 500);
    if (!rdy) chk(1'b0, "xfer_timeout", 512'(t), 512'(500));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic send_msg(input bit emk);
    int n = msg_q.size();
    for (int i = 0; i < n; i++) xfer(msg_q[i], (i == n - 1) && !emk, 1'b0);
    if (emk || n == 0) xfer(8'h00, 1'b1, 1'b1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || !bus.in_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 1000, "drain_timeout", 512'(t), 512'(1000));
    @(posedge clk); #1;
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // "abc" held under back-pressure so the block is checked directly too.
  task automatic abc_check(input string nm);
    logic [0:511] exp_abc;
    exp_abc = '0;
    exp_abc[0:31]    = 32'h61626380;
    exp_abc[448:511] = 64'h18;
    bus.blk_ready = 1'b0;
    load_abc();
    push_expected();
    send_msg(1'b0);
    chk(bus.blk_valid === 1'b1, {nm, "_valid_next_cycle"}, 512'(bus.blk_valid), 512'(1));
    chk(bus.blk === exp_abc, {nm, "_block"}, 512'(bus.blk), 512'(exp_abc));
    chk(bus.blk_last === 1'b1, {nm, "_last"}, 512'(bus.blk_last), 512'(1));
    bus.blk_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[10];
    logic [0:511] snap;

    vecs[0] = '{0,   0, 8'h00, 1'b1, 1};
    vecs[1] = '{3,   1, 8'h61, 1'b0, 1};
    vecs[2] = '{55,  0, 8'h00, 1'b0, 1};
    vecs[3] = '{56,  0, 8'h00, 1'b0, 2};
    vecs[4] = '{63,  1, 8'h10, 1'b0, 2};
    vecs[5] = '{64,  0, 8'hFF, 1'b0, 2};
    vecs[6] = '{64,  1, 8'h00, 1'b1, 2};
    vecs[7] = '{119, 1, 8'h03, 1'b0, 2};
    vecs[8] = '{120, 0, 8'h5A, 1'b0, 3};
    vecs[9] = '{128, 1, 8'h80, 1'b0, 3};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.in_empty  = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.in_ready === 1'b1, "rst_in_ready", 512'(bus.in_ready), 512'(1));
    chk(bus.blk_valid === 1'b0, "rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    chk(bus.blk_last === 1'b0, "rst_blk_last", 512'(bus.blk_last), 512'(0));
    chk(bus.blk === '0, "rst_blk", 512'(bus.blk), '0);
`ifdef SHA256_PAD_OVF_EN
    chk(ovf === 1'b0, "rst_ovf", 512'(ovf), 512'(0));
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven messages.
    for (int v = 0; v < 10; v++) begin
      msg_q.delete();
      for (int i = 0; i < vecs[v].n; i++)
        msg_q.push_back(vecs[v].mode == 0 ? vecs[v].val : 8'(vecs[v].val + 8'(i)));
      push_expected();
      nblk = 0;
      send_msg(vecs[v].emk);
      wait_drain();
      chk(nblk == vecs[v].exp_blocks, $sformatf("vec%0d_nblocks", v),
          512'(nblk), 512'(vecs[v].exp_blocks));
    end

    // Exact "abc" block, available the cycle after the last byte.
    abc_check("abc");

    // Back-pressure during EMIT: block frozen, input refused.
    bus.blk_ready = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'hFF);
    push_expected();
    send_msg(1'b0);
    snap = bus.blk;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      @(posedge clk); #1;
      chk(bus.blk === snap, "bp_blk_stable", 512'(bus.blk), 512'(snap));
      chk(bus.in_ready === 1'b0, "bp_in_ready", 512'(bus.in_ready), 512'(0));
      chk(bus.blk_valid === 1'b1, "bp_blk_valid", 512'(bus.blk_valid), 512'(1));
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b1;
    wait_drain();

    // Reset after 10 bytes discards the partial message.
    for (int i = 0; i < 10; i++) xfer(8'(8'hA0 + 8'(i)), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk(bus.blk === '0, "midrst_blk", 512'(bus.blk), '0);
    chk(bus.in_ready === 1'b1, "midrst_in_ready", 512'(bus.in_ready), 512'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    abc_check("abc_after_reset");

    chk(sb.size() == 0, "sb_empty", 512'(sb.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
